// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path: default widths,
// the hardwired zero register and the two-port grant encoding.
package rf_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_NUM_REGS = 32;

   localparam int ZERO_REG = 0;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The single state bit remembers the most
// recent grant so that contention always goes to the other requester.
module rr_arb2
   import rf_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic last;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (req_a && req_b) begin
         gnt_a = (last == PORT_B);
         gnt_b = (last == PORT_A);
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end
   end

   // Reset value favours A on the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= PORT_B;
      end else if (gnt_a || gnt_b) begin
         // NOTE: non-blocking assignment for state, so every flop samples pre-edge values.
         last <= gnt_b ? PORT_B : PORT_A;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths,
// registers the granted write and tracks in-flight destinations for RAW detection.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   input  logic [ADDR_W-1:0]   a_reg,
   input  logic [DATA_W-1:0]   a_data,
   output logic                a_ready,
   input  logic                b_valid,
   input  logic [ADDR_W-1:0]   b_reg,
   input  logic [DATA_W-1:0]   b_data,
   output logic                b_ready,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_reg,
   input  logic [ADDR_W-1:0]   src1,
   input  logic [ADDR_W-1:0]   src2,
   output logic                hazard,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata
);

   localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(ZERO_REG);

   logic                gnt_a;
   logic                gnt_b;
   logic                xfer;
   logic                wr_hit;
   logic [ADDR_W-1:0]   sel_reg;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_REGS-1:0] busy_next;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_a (a_valid),
      .req_b (b_valid),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;
   assign xfer    = gnt_a | gnt_b;

   always_comb begin
      sel_reg  = a_reg;
      sel_data = a_data;
      if (gnt_b) begin
         sel_reg  = b_reg;
         sel_data = b_data;
      end
   end

   // A transfer to the zero register retires normally but never writes.
   assign wr_hit = xfer && (sel_reg != REG0);

   // Clear first, then set, so a newer producer issuing this cycle stays pending.
   always_comb begin
      busy_next = busy_mask;
      if (xfer) begin
         busy_next[sel_reg] = 1'b0;
      end
      if (issue_valid && (issue_reg != REG0)) begin
         busy_next[issue_reg] = 1'b1;
      end
      busy_next[REG0] = 1'b0;
   end

   assign hazard = busy_mask[src1] | busy_mask[src2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset like any register.
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
         rf_we     <= wr_hit;
         if (wr_hit) begin
            rf_waddr <= sel_reg;
            rf_wdata <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_rf_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_reg = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_reg = '0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic          issue_valid = 1'b0;
   logic [AW-1:0] issue_reg = '0;
   logic [AW-1:0] src1 = '0;
   logic [AW-1:0] src2 = '0;
   logic          hazard;
   logic [NR-1:0] busy_mask;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_reg       (a_reg),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_reg       (b_reg),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .src1        (src1),
      .src2        (src2),
      .hazard      (hazard),
      .busy_mask   (busy_mask),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who was granted last, which registers are pending,
   // and what the register-file port should show this cycle.
   bit            m_last_b;
   bit            m_busy [NR];
   bit            m_we;
   bit [AW-1:0]   m_waddr;
   bit [DW-1:0]   m_wdata;
   bit            m_known;
   bit            g_a;
   bit            g_b;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR-1:0] model_mask();
      logic [NR-1:0] m;
      for (int i = 0; i < NR; i++) m[i] = m_busy[i];
      return m;
   endfunction

   function automatic logic [AW-1:0] rnd_reg();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NR - 1));
   endfunction

   task automatic model_reset();
      m_last_b = 1'b1;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_known = 1'b1;
   endtask

   // One clock cycle: inputs are already driven; compare, then advance the model.
   task automatic step();
      bit [AW-1:0] r;
      bit [DW-1:0] d;
      #1;
      g_a = 1'b0;
      g_b = 1'b0;
      if (a_valid && b_valid) begin
         if (m_last_b) g_a = 1'b1;
         else          g_b = 1'b1;
      end else begin
         g_a = a_valid;
         g_b = b_valid;
      end
      check("a_ready", a_ready, g_a);
      check("b_ready", b_ready, g_b);
      check("one_ready", a_ready & b_ready, 0);
      check("busy_mask", busy_mask, model_mask());
      check("hazard", hazard, m_busy[src1] | m_busy[src2]);
      check("rf_we", rf_we, m_we);
      if (m_known) begin
         check("rf_waddr", rf_waddr, m_waddr);
         check("rf_wdata", rf_wdata, m_wdata);
      end
      if (!rst) begin
         if (g_a || g_b) begin
            r = g_a ? a_reg : b_reg;
            d = g_a ? a_data : b_data;
            m_last_b = g_b;
            m_busy[r] = 1'b0;
            if (r != 0) begin
               m_we = 1'b1; m_waddr = r; m_wdata = d; m_known = 1'b1;
            end else begin
               m_we = 1'b0; m_known = 1'b0;
            end
         end else begin
            m_we = 1'b0;
         end
         if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
      src1 = '0; src2 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      model_reset();
      step();
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      model_reset();
      step();
      rst = 1'b0;

      // Single A write, then hold of the port address/data when idle.
      a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
      step();
      a_valid = 1'b0;
      step();
      step();

      // Continuous contention straight out of reset: A, B, A, B.
      do_reset();
      a_valid = 1'b1; a_reg = 5'd1; b_valid = 1'b1; b_reg = 5'd2;
      for (int i = 0; i < 4; i++) begin
         a_data = $urandom; b_data = $urandom;
         step();
      end
      clear_inputs();
      step();

      // RAW hazard raised by issue, cleared by B writeback.
      issue_valid = 1'b1; issue_reg = 5'd7;
      step();
      issue_valid = 1'b0; src1 = 5'd7;
      step();
      b_valid = 1'b1; b_reg = 5'd7; b_data = $urandom;
      step();
      b_valid = 1'b0;
      step();

      // Same-cycle issue and writeback of reg 3: the set wins.
      issue_valid = 1'b1; issue_reg = 5'd3;
      step();
      a_valid = 1'b1; a_reg = 5'd3; a_data = $urandom;
      step();
      clear_inputs();
      step();
      check("busy3_set_wins", busy_mask[3], 1);

      // Zero register: handshake completes, no write, never marked busy.
      a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h1234;
      issue_valid = 1'b1; issue_reg = 5'd0;
      step();
      clear_inputs();
      step();

      // Asynchronous reset in the middle of a cycle with B pending.
      issue_valid = 1'b1; issue_reg = 5'd4;
      b_valid = 1'b1; b_reg = 5'd9; b_data = $urandom;
      step();
      issue_valid = 1'b0; src1 = 5'd4;
      b_reg = 5'd10; b_data = $urandom;
      #2;
      check("pre_rst_we", rf_we, m_we);
      rst = 1'b1;
      #1;
      check("rst_rf_we", rf_we, 0);
      check("rst_busy", busy_mask, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_hazard", hazard, 0);
      check("rst_b_ready", b_ready, 1);
      rst = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      step();

      // Randomized traffic with the hold-until-ready rule on both ports.
      for (int i = 0; i < 1500; i++) begin
         if (!a_valid || g_a) begin
            a_valid = ($urandom_range(0, 99) < 60);
            a_reg = rnd_reg(); a_data = $urandom;
         end
         if (!b_valid || g_b) begin
            b_valid = ($urandom_range(0, 99) < 60);
            b_reg = rnd_reg(); b_data = $urandom;
         end
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_reg = rnd_reg();
         src1 = rnd_reg();
         src2 = rnd_reg();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
